// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared types and constants for the PDM microphone deserializer
package mic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } mic_state_t;

    localparam int WORD_BITS       = 32;
    localparam int CNT_W           = $clog2(WORD_BITS);
    localparam int PKT_W           = 10;
    localparam int DEF_HALF_PERIOD = 20;
    localparam int DEF_PACKETS     = 937;

endpackage

// File: rtl/mic_clk_gen.sv
// rtl/mic_clk_gen.sv - mic clock divider producing the per-bit sample tick
module mic_clk_gen #(
    parameter int HALF_PERIOD = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic mic_clk,
    output logic sample_tick
);

    localparam int DIV_W = $clog2(HALF_PERIOD + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

    logic [DIV_W-1:0] divider;

    // The toggle that drives mic_clk high is the moment the bit is taken.
    assign sample_tick = run && (divider == DIV_LAST) && !mic_clk;

    // Divider and mic_clk are parked at zero whenever the FSM is not capturing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= '0;
            mic_clk <= 1'b0;
        end else if (!run) begin
            divider <= '0;
            mic_clk <= 1'b0;
        end else if (divider == DIV_LAST) begin
            divider <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mic_deserializer.sv
// rtl/mic_deserializer.sv - PDM mic capture: synchronize, shift MSB-first, count words
module mic_deserializer
    import mic_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int PACKETS     = DEF_PACKETS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mic_data,
    output logic                 mic_clk,
    output logic                 mic_lrsel,
    output logic [WORD_BITS-1:0] shifted_micData,
    output logic [CNT_W-1:0]     thirty_two_count,
    output logic [PKT_W-1:0]     packets,
    output logic                 word_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKETS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);

    if (PACKETS < 1 || PACKETS > (1 << PKT_W)) begin : g_bad_packets
        $error("mic_deserializer: PACKETS must be in 1..1024");
    end
    if (HALF_PERIOD < 1) begin : g_bad_half_period
        $error("mic_deserializer: HALF_PERIOD must be at least 1");
    end

    mic_state_t state;
    logic       sync_1;
    logic       sync_2;
    logic       sample_tick;

    // Left/right select tied so the mic drives data for the rising-edge channel.
    assign mic_lrsel = 1'b0;

    mic_clk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_clk_gen (
        .clk         (clk),
        .rst_n       (reset),
        .run         (state == ST_CAPTURE),
        .mic_clk     (mic_clk),
        .sample_tick (sample_tick)
    );

    // Two-flop synchronizer for the asynchronous mic data line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= mic_data;
            sync_2 <= sync_1;
        end
    end

    // Capture FSM: shift one bit per tick, close words, end the run after the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            shifted_micData  <= '0;
            thirty_two_count <= '0;
            packets          <= '0;
            word_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    thirty_two_count <= '0;
                    packets          <= '0;
                    if (enable) begin
                        state <= ST_CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_tick) begin
                        shifted_micData <= {shifted_micData[WORD_BITS-2:0], sync_2};
                        if (thirty_two_count == CNT_LAST) begin
                            thirty_two_count <= '0;
                            word_valid       <= 1'b1;
                            if (packets == PKT_LAST) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                packets <= packets + PKT_W'(1);
                            end
                        end else begin
                            thirty_two_count <= thirty_two_count + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    packets <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_deserializer.sv
// tb/tb_mic_deserializer.sv - scoreboard bench for mic_deserializer with random PDM words
module tb_mic_deserializer;
    import mic_pkg::*;

    localparam int HP = 2;
    localparam int P  = 3;
    localparam int NB = P * WORD_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mic_data = 1'b0;
    logic        mic_clk;
    logic        mic_lrsel;
    logic [31:0] shifted_micData;
    logic [4:0]  thirty_two_count;
    logic [9:0]  packets;
    logic        word_valid;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] word;
        int          pk;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] data[P];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    mic_deserializer #(
        .HALF_PERIOD (HP),
        .PACKETS     (P)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .mic_data         (mic_data),
        .mic_clk          (mic_clk),
        .mic_lrsel        (mic_lrsel),
        .shifted_micData  (shifted_micData),
        .thirty_two_count (thirty_two_count),
        .packets          (packets),
        .word_valid       (word_valid),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic bit_at(input int i);
        logic [31:0] w;
        w = data[i / WORD_BITS];
        return w[WORD_BITS - 1 - (i % WORD_BITS)];
    endfunction

    // Monitor: every presented word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (word_valid) begin
                if (sb.size() == 0) begin
                    check("word_valid_unexpected", word_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_data", shifted_micData, mon_e.word);
                    check("word_packets", packets, mon_e.pk);
                    check("word_count", thirty_two_count, 0);
                    check("word_done", done, mon_e.last);
                end
            end else if (done) begin
                check("done_without_word", done, 0);
            end
        end
    end

    // One capture run; abort_at >= 0 pulls reset low just before that bit is sampled.
    task automatic run_capture(input int abort_at, input bit poke);
        int nbits;
        int d0;
        nbits = (abort_at < 0) ? NB : abort_at;
        d0 = done_cnt;
        for (int w = 0; w < nbits / WORD_BITS; w++)
            sb.push_back('{data[w], (w < P - 1) ? w + 1 : P - 1, w == P - 1});

        @(negedge clk);
        mic_data = bit_at(0);
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        check("busy_start", busy, 1);
        repeat (HP) @(posedge clk);
        #1 check("mic_clk_first_rise", mic_clk, 1);

        for (int i = 1; i < NB; i++) begin
            @(negedge clk);
            check("count_mid", thirty_two_count, i % WORD_BITS);
            check("packets_mid", packets, i / WORD_BITS);
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_packets", packets, 0);
                check("abort_count", thirty_two_count, 0);
                check("abort_mic_clk", mic_clk, 0);
                check("abort_busy", busy, 0);
                check("abort_data", shifted_micData, 0);
                @(negedge clk);
                reset = 1'b1;
                repeat (40) @(negedge clk);
                check("abort_no_done", done_cnt - d0, 0);
                check("abort_idle", busy, 0);
                check("abort_sb_empty", sb.size(), 0);
                return;
            end
            mic_data = bit_at(i);
            if (poke && $urandom_range(0, 3) == 0) begin
                enable = 1'b1;
                @(posedge clk);
                #1 enable = 1'b0;
                repeat (2 * HP - 1) @(posedge clk);
            end else begin
                repeat (2 * HP) @(posedge clk);
            end
        end

        @(negedge clk);
        enable = poke;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (5) @(negedge clk);
        check("end_busy", busy, 0);
        check("end_mic_clk", mic_clk, 0);
        check("end_packets", packets, 0);
        check("end_count", thirty_two_count, 0);
        check("end_sb_empty", sb.size(), 0);
        check("end_done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        bit seen;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mic_clk", mic_clk, 0);
        check("rst_lrsel", mic_lrsel, 0);
        check("rst_data", shifted_micData, 0);
        check("rst_count", thirty_two_count, 0);
        check("rst_packets", packets, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;

        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (mic_clk || busy || word_valid || done || mic_lrsel) seen = 1'b1;
        end
        check("idle_quiet", seen, 0);

        for (int w = 0; w < P; w++) data[w] = 32'hFFFF_FFFF;
        run_capture(-1, 1'b0);

        data[0] = 32'hAAAA_AAAA;
        for (int w = 1; w < P; w++) data[w] = $urandom();
        run_capture(-1, 1'b0);

        for (int w = 0; w < P; w++) data[w] = $urandom();
        run_capture(WORD_BITS + 17, 1'b0);

        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < P; w++) data[w] = $urandom();
            run_capture(-1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
